// File: rtl/memwb_if.sv
// MEM->WB bus between the M stage and the W stage: M-stage fields, stall/flush control in, W-stage fields out.
interface memwb_if #(
  parameter int XLEN      = 32,
  parameter int LANES     = 1,
  parameter int OP_W      = 5,
  parameter int NUM_STALL = 1
);
  logic [NUM_STALL-1:0]    stall_i;
  logic                    dm_stall_i;
  logic                    flush_i;
  logic [LANES-1:0]        m_valid_i;
  logic [LANES*OP_W-1:0]   m_op_i;
  logic [LANES*5-1:0]      m_rd_i;
  logic [LANES*3-1:0]      m_func3_i;
  logic [LANES*XLEN-1:0]   m_alu_i;
  logic [LANES*XLEN-1:0]   m_rdata_i;
  logic [LANES-1:0]        w_valid_o;
  logic [LANES*OP_W-1:0]   w_op_o;
  logic [LANES*5-1:0]      w_rd_o;
  logic [LANES*3-1:0]      w_func3_o;
  logic [LANES*XLEN-1:0]   w_alu_o;
  logic [LANES*XLEN-1:0]   w_rdata_o;
  logic [LANES-1:0]        cap_valid_o;

  modport master (
    output stall_i, dm_stall_i, flush_i, m_valid_i, m_op_i, m_rd_i, m_func3_i, m_alu_i, m_rdata_i,
    input  w_valid_o, w_op_o, w_rd_o, w_func3_o, w_alu_o, w_rdata_o, cap_valid_o
  );

  modport slave (
    input  stall_i, dm_stall_i, flush_i, m_valid_i, m_op_i, m_rd_i, m_func3_i, m_alu_i, m_rdata_i,
    output w_valid_o, w_op_o, w_rd_o, w_func3_o, w_alu_o, w_rdata_o, cap_valid_o
  );
endinterface

// File: rtl/memwb_pipe_reg.sv
// MEM->WB pipeline register with per-lane load-data capture buffer, deferred flush and N stall sources.
// Optional MEMWB_PERF_EN adds stall-cycle and capture-event counters.
module memwb_pipe_reg #(
  parameter int XLEN      = 32,
  parameter int LANES     = 1,
  parameter int OP_W      = 5,
  parameter int NUM_STALL = 1
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MEMWB_PERF_EN
  output logic [31:0] stall_cyc_o,
  output logic [15:0] cap_evt_o,
`endif
  memwb_if.slave      bus
);

  logic                  advance;
  logic                  capture_en;
  logic                  flush_any;
  logic [LANES-1:0]      cap_new;

  logic [LANES-1:0]      w_valid_d,  w_valid_q;
  logic [LANES*OP_W-1:0] w_op_d,     w_op_q;
  logic [LANES*5-1:0]    w_rd_d,     w_rd_q;
  logic [LANES*3-1:0]    w_func3_d,  w_func3_q;
  logic [LANES*XLEN-1:0] w_alu_d,    w_alu_q;
  logic [LANES*XLEN-1:0] w_rdata_d,  w_rdata_q;
  logic [LANES-1:0]      cap_valid_d, cap_valid_q;
  logic [LANES*XLEN-1:0] cap_buf_d,  cap_buf_q;
  logic                  flush_pend_d, flush_pend_q;

  assign advance   = ~bus.dm_stall_i & ~(|bus.stall_i);
  assign flush_any = bus.flush_i | flush_pend_q;
  // Only latch DM data when DM itself has delivered but something else froze the pipe;
  // a pending flush makes the data worthless, so it is not captured either.
  assign capture_en = ~bus.dm_stall_i & (|bus.stall_i) & ~flush_any;

  always_comb begin
    w_valid_d    = w_valid_q;
    w_op_d       = w_op_q;
    w_rd_d       = w_rd_q;
    w_func3_d    = w_func3_q;
    w_alu_d      = w_alu_q;
    w_rdata_d    = w_rdata_q;
    cap_valid_d  = cap_valid_q;
    cap_buf_d    = cap_buf_q;
    flush_pend_d = flush_pend_q;
    cap_new      = '0;

    if (advance) begin
      if (flush_any) begin
        w_valid_d = '0;
        w_op_d    = '0;
        w_rd_d    = '0;
        w_func3_d = '0;
        w_alu_d   = '0;
        w_rdata_d = '0;
      end else begin
        w_valid_d = bus.m_valid_i;
        w_op_d    = bus.m_op_i;
        w_rd_d    = bus.m_rd_i;
        w_func3_d = bus.m_func3_i;
        w_alu_d   = bus.m_alu_i;
        for (int l = 0; l < LANES; l++) begin
          w_rdata_d[l*XLEN +: XLEN] = cap_valid_q[l] ? cap_buf_q[l*XLEN +: XLEN]
                                                     : bus.m_rdata_i[l*XLEN +: XLEN];
        end
      end
      cap_valid_d  = '0;
      cap_buf_d    = '0;
      flush_pend_d = 1'b0;
    end else if (bus.flush_i) begin
      flush_pend_d = 1'b1;
      cap_valid_d  = '0;
      cap_buf_d    = '0;
    end else if (capture_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (!cap_valid_q[l]) begin
          cap_new[l]                = 1'b1;
          cap_valid_d[l]            = 1'b1;
          cap_buf_d[l*XLEN +: XLEN] = bus.m_rdata_i[l*XLEN +: XLEN];
        end
      end
    end
  end

  // M -> W stage boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid_q    <= '0;
      w_op_q       <= '0;
      w_rd_q       <= '0;
      w_func3_q    <= '0;
      w_alu_q      <= '0;
      w_rdata_q    <= '0;
      cap_valid_q  <= '0;
      cap_buf_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      w_valid_q    <= w_valid_d;
      w_op_q       <= w_op_d;
      w_rd_q       <= w_rd_d;
      w_func3_q    <= w_func3_d;
      w_alu_q      <= w_alu_d;
      w_rdata_q    <= w_rdata_d;
      cap_valid_q  <= cap_valid_d;
      cap_buf_q    <= cap_buf_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.w_valid_o   = w_valid_q;
  assign bus.w_op_o      = w_op_q;
  assign bus.w_rd_o      = w_rd_q;
  assign bus.w_func3_o   = w_func3_q;
  assign bus.w_alu_o     = w_alu_q;
  assign bus.w_rdata_o   = w_rdata_q;
  assign bus.cap_valid_o = cap_valid_q;

`ifdef MEMWB_PERF_EN
  logic [31:0] stall_cyc_d, stall_cyc_q;
  logic [15:0] cap_evt_d,   cap_evt_q;
  logic [15:0] cap_inc;

  always_comb begin
    cap_inc = '0;
    for (int l = 0; l < LANES; l++) begin
      cap_inc = cap_inc + 16'(cap_new[l]);
    end
    stall_cyc_d = stall_cyc_q;
    if (!advance && (stall_cyc_q != 32'hFFFF_FFFF)) begin
      stall_cyc_d = stall_cyc_q + 32'd1;
    end
    cap_evt_d = cap_evt_q + cap_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cyc_q <= '0;
      cap_evt_q   <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      cap_evt_q   <= cap_evt_d;
    end
  end

  assign stall_cyc_o = stall_cyc_q;
  assign cap_evt_o   = cap_evt_q;
`endif

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Directed bench for memwb_pipe_reg (2 lanes): advance, stall capture, DM stall, flush, async reset.
module tb_memwb_pipe_reg;
  localparam int XLEN = 32;
  localparam int LANES = 2;
  localparam int OP_W = 5;
  localparam int NUM_STALL = 1;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  memwb_if #(.XLEN(XLEN), .LANES(LANES), .OP_W(OP_W), .NUM_STALL(NUM_STALL)) bus ();

`ifdef MEMWB_PERF_EN
  logic [31:0] stall_cyc;
  logic [15:0] cap_evt;
`endif

  memwb_pipe_reg #(.XLEN(XLEN), .LANES(LANES), .OP_W(OP_W), .NUM_STALL(NUM_STALL)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef MEMWB_PERF_EN
    .stall_cyc_o (stall_cyc),
    .cap_evt_o   (cap_evt),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1;
    bus.stall_i    = '0;
    bus.dm_stall_i = 1'b0;
    bus.flush_i    = 1'b0;
    bus.m_valid_i  = 2'b11;
    bus.m_op_i     = {5'h07, 5'h07};
    bus.m_rd_i     = {5'd9, 5'd9};
    bus.m_func3_i  = 6'h3F;
    bus.m_alu_i    = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.m_rdata_i  = 64'h1234_5678_9ABC_DEF0;
    step();
    step();
    chk("rst_w_valid", 64'(bus.w_valid_o), 64'h0);
    chk("rst_w_rdata", bus.w_rdata_o, 64'h0);
    chk("rst_w_alu", bus.w_alu_o, 64'h0);
    chk("rst_cap_valid", 64'(bus.cap_valid_o), 64'h0);
    rst = 1'b0;

    // plain advance on lane 0, lane 1 a bubble
    bus.m_valid_i = 2'b01;
    bus.m_op_i    = {5'h00, 5'h03};
    bus.m_rd_i    = {5'd0, 5'd5};
    bus.m_func3_i = {3'd0, 3'd2};
    bus.m_alu_i   = {32'h0, 32'h0000_0100};
    bus.m_rdata_i = {32'h0, 32'hDEAD_BEEF};
    step();
    chk("adv_w_valid", 64'(bus.w_valid_o), 64'h1);
    chk("adv_w_op", 64'(bus.w_op_o[4:0]), 64'h3);
    chk("adv_w_rd", 64'(bus.w_rd_o[4:0]), 64'h5);
    chk("adv_w_func3", 64'(bus.w_func3_o[2:0]), 64'h2);
    chk("adv_w_alu", 64'(bus.w_alu_o[31:0]), 64'h100);
    chk("adv_w_rdata", 64'(bus.w_rdata_o[31:0]), 64'hDEAD_BEEF);

    // IM stall: first returned data is captured, later changes ignored
    bus.stall_i   = 1'b1;
    bus.m_rdata_i = {32'h0, 32'hAAAA_5555};
    step();
    chk("im_cap_valid", 64'(bus.cap_valid_o), 64'h3);
    chk("im_hold_rdata", 64'(bus.w_rdata_o[31:0]), 64'hDEAD_BEEF);
    bus.m_rdata_i = '0;
    for (int i = 0; i < 3; i++) step();
    chk("im_cap_held", 64'(bus.cap_valid_o), 64'h3);
    bus.stall_i = 1'b0;
    step();
    chk("im_rel_rdata", 64'(bus.w_rdata_o[31:0]), 64'hAAAA_5555);
    chk("im_rel_cap", 64'(bus.cap_valid_o), 64'h0);

    // DM stall blocks capture; capture once DM delivers under IM stall
    bus.stall_i    = 1'b1;
    bus.dm_stall_i = 1'b1;
    bus.m_rdata_i  = {32'hBAD0_BAD0, 32'hBAD0_BAD0};
    step();
    step();
    chk("dm_no_cap", 64'(bus.cap_valid_o), 64'h0);
    chk("dm_hold_rdata", 64'(bus.w_rdata_o[31:0]), 64'hAAAA_5555);
    bus.dm_stall_i = 1'b0;
    bus.m_rdata_i  = {32'h0, 32'h0000_1234};
    step();
    chk("dm_cap_valid", 64'(bus.cap_valid_o), 64'h3);
    bus.stall_i   = 1'b0;
    bus.m_rdata_i = '0;
    step();
    chk("dm_rel_rdata", 64'(bus.w_rdata_o[31:0]), 64'h1234);

    // flush while stalled: deferred bubble on release
    bus.stall_i   = 1'b1;
    bus.m_rdata_i = {32'h0, 32'h0000_0055};
    step();
    chk("fl_cap_valid", 64'(bus.cap_valid_o), 64'h3);
    bus.flush_i = 1'b1;
    step();
    chk("fl_cap_clr", 64'(bus.cap_valid_o), 64'h0);
    chk("fl_w_kept", 64'(bus.w_valid_o), 64'h1);
    bus.flush_i = 1'b0;
    step();
    bus.stall_i = 1'b0;
    step();
    chk("fl_w_valid", 64'(bus.w_valid_o), 64'h0);
    chk("fl_w_rd", 64'(bus.w_rd_o), 64'h0);
    chk("fl_w_op", 64'(bus.w_op_o), 64'h0);
    chk("fl_w_rdata", bus.w_rdata_o, 64'h0);

    // two lanes: lane 0 valid, lane 1 bubble, both capture
    bus.m_valid_i = 2'b01;
    bus.stall_i   = 1'b1;
    bus.m_rdata_i = {32'h0000_0022, 32'h0000_0011};
    step();
    bus.m_rdata_i = {32'h0000_0033, 32'h0000_00FF};
    step();
    bus.stall_i = 1'b0;
    step();
    chk("l2_w_valid", 64'(bus.w_valid_o), 64'h1);
    chk("l2_rdata0", 64'(bus.w_rdata_o[31:0]), 64'h11);
    chk("l2_rdata1", 64'(bus.w_rdata_o[63:32]), 64'h22);

    // flush on an advancing edge: bubble immediately
    bus.m_valid_i = 2'b11;
    bus.flush_i   = 1'b1;
    step();
    chk("fa_w_valid", 64'(bus.w_valid_o), 64'h0);
    chk("fa_w_alu", bus.w_alu_o, 64'h0);
    bus.flush_i = 1'b0;

    // async reset in the middle of a capture
    bus.m_valid_i = 2'b01;
    bus.m_rdata_i = {32'h0, 32'h0000_0099};
    step();
    chk("ar_pre_valid", 64'(bus.w_valid_o), 64'h1);
    bus.stall_i   = 1'b1;
    bus.m_rdata_i = {32'h0, 32'h0000_0077};
    step();
    #2 rst = 1'b1;
    #1;
    chk("ar_w_valid", 64'(bus.w_valid_o), 64'h0);
    chk("ar_w_rdata", bus.w_rdata_o, 64'h0);
    chk("ar_w_alu", bus.w_alu_o, 64'h0);
    chk("ar_cap_valid", 64'(bus.cap_valid_o), 64'h0);
    rst = 1'b0;
    bus.m_rdata_i = {32'h0, 32'h0000_00CC};
    for (int i = 0; i < 3; i++) step();
`ifdef MEMWB_PERF_EN
    chk("perf_stall_cyc", 64'(stall_cyc), 64'd3);
    chk("perf_cap_evt", 64'(cap_evt), 64'd2);
`endif
    bus.stall_i   = 1'b0;
    bus.m_rdata_i = '0;
    step();
    chk("ar_new_rdata", 64'(bus.w_rdata_o[31:0]), 64'hCC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
